// File: rtl/backend_pkg.sv
// Shared backend definitions: ROB state encodings, the hardwired-zero register index
// and the default widths used by the alias table.
package backend_pkg;
  typedef enum logic [1:0] {
    ISSUED    = 2'd0,
    EXECUTED  = 2'd1,
    WROTE     = 2'd2,
    COMMITTED = 2'd3
  } rob_state_e;

  localparam int ARCH_ZERO          = 0;
  localparam int DEF_ROB_ENTRY      = 4;
  localparam int DEF_ARCH_ENTRY     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_ROB_ENTRY_LOG2 = $clog2(DEF_ROB_ENTRY);
  localparam int DEF_ARCH_LOG2      = $clog2(DEF_ARCH_ENTRY);
endpackage

// File: rtl/register_alias_table_if.sv
// Commit, rename and operand-lookup signals between the ROB/issuer (master)
// and the register alias table (slave).
interface register_alias_table_if
  import backend_pkg::*;
#(
  parameter int ROB_ENTRY_LOG2  = DEF_ROB_ENTRY_LOG2,
  parameter int ARCH_ENTRY_LOG2 = DEF_ARCH_LOG2,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH
);
  logic                       cdb_isr_request;
  logic                       cdb_isr_grant;
  logic [ARCH_ENTRY_LOG2-1:0] cdb_isr_arch_id;
  logic [ROB_ENTRY_LOG2-1:0]  cdb_isr_id;
  logic [DATA_WIDTH-1:0]      cdb_isr_data;
  logic                       rat_register_request;
  logic [ARCH_ENTRY_LOG2-1:0] rat_register_arch_id;
  logic [ROB_ENTRY_LOG2-1:0]  rat_register_alias;
  logic                       rat_register_remove;
  logic                       commit_hold;
  logic                       rat_flush;
  logic [ARCH_ENTRY_LOG2-1:0] rs1_arch_id, rs2_arch_id;
  logic                       rs1_ready, rs2_ready;
  logic [DATA_WIDTH-1:0]      rs1_data, rs2_data;
  logic [ROB_ENTRY_LOG2-1:0]  rs1_alias, rs2_alias;
  logic [31:0]                retire_count;

  modport master (
    output cdb_isr_request, cdb_isr_arch_id, cdb_isr_id, cdb_isr_data,
           rat_register_request, rat_register_arch_id, rat_register_alias,
           rat_register_remove, commit_hold, rat_flush, rs1_arch_id, rs2_arch_id,
    input  cdb_isr_grant, rs1_ready, rs2_ready, rs1_data, rs2_data,
           rs1_alias, rs2_alias, retire_count
  );

  modport slave (
    input  cdb_isr_request, cdb_isr_arch_id, cdb_isr_id, cdb_isr_data,
           rat_register_request, rat_register_arch_id, rat_register_alias,
           rat_register_remove, commit_hold, rat_flush, rs1_arch_id, rs2_arch_id,
    output cdb_isr_grant, rs1_ready, rs2_ready, rs1_data, rs2_data,
           rs1_alias, rs2_alias, retire_count
  );
endinterface

// File: rtl/register_alias_table_lookup.sv
// One source-operand lookup: committed value, same-cycle commit bypass, or the
// ROB tag the issuer must wait on.
module rat_lookup_port
  import backend_pkg::*;
#(
  parameter int ARCH_ENTRY      = DEF_ARCH_ENTRY,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ROB_ENTRY_LOG2  = DEF_ROB_ENTRY_LOG2,
  parameter int ARCH_ENTRY_LOG2 = DEF_ARCH_LOG2
) (
  input  logic [ARCH_ENTRY_LOG2-1:0]                 rs_i,
  input  logic [ARCH_ENTRY-1:0]                      busy_i,
  input  logic [ARCH_ENTRY-1:0][ROB_ENTRY_LOG2-1:0]  alias_i,
  input  logic [ARCH_ENTRY-1:0][DATA_WIDTH-1:0]      regs_i,
  input  logic                                       commit_fire_i,
  input  logic [ARCH_ENTRY_LOG2-1:0]                 commit_arch_i,
  input  logic [ROB_ENTRY_LOG2-1:0]                  commit_id_i,
  input  logic [DATA_WIDTH-1:0]                      commit_data_i,
  output logic                                       ready_o,
  output logic [DATA_WIDTH-1:0]                      data_o,
  output logic [ROB_ENTRY_LOG2-1:0]                  alias_o
);
  always_comb begin
    ready_o = 1'b1;
    data_o  = '0;
    alias_o = '0;
    if (rs_i == ARCH_ENTRY_LOG2'(ARCH_ZERO)) begin
      ready_o = 1'b1;
    end else if (commit_fire_i && commit_arch_i == rs_i && busy_i[rs_i] &&
                 alias_i[rs_i] == commit_id_i) begin
      data_o = commit_data_i;
    end else if (busy_i[rs_i]) begin
      ready_o = 1'b0;
      alias_o = alias_i[rs_i];
    end else begin
      data_o = regs_i[rs_i];
    end
  end
endmodule

// File: rtl/register_alias_table.sv
// Architectural register file with per-register alias records; accepts renames from
// the ROB tail, in-order commits from the ROB head, and serves two operand lookups.
module register_alias_table
  import backend_pkg::*;
#(
  parameter int ROB_ENTRY       = DEF_ROB_ENTRY,
  parameter int ARCH_ENTRY      = DEF_ARCH_ENTRY,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
  parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
  input logic                    CLK,
  input logic                    RST,
  register_alias_table_if.slave  bus
);
  logic [ARCH_ENTRY-1:0][DATA_WIDTH-1:0]     regs_q, regs_d;
  logic [ARCH_ENTRY-1:0]                     busy_q, busy_d;
  logic [ARCH_ENTRY-1:0][ROB_ENTRY_LOG2-1:0] alias_q, alias_d;
  logic [31:0]                               retire_q, retire_d;
  logic                                      commit_fire;

  assign bus.cdb_isr_grant = bus.cdb_isr_request & ~bus.commit_hold & ~bus.rat_flush & ~RST;
  assign commit_fire       = bus.cdb_isr_request & bus.cdb_isr_grant;
  assign bus.retire_count  = retire_q;

  // Statement order sets priority: commit clear, then flush, then rename wins.
  always_comb begin
    regs_d   = regs_q;
    busy_d   = busy_q;
    alias_d  = alias_q;
    retire_d = retire_q;
    if (commit_fire) begin
      if (bus.cdb_isr_arch_id != ARCH_ENTRY_LOG2'(ARCH_ZERO))
        regs_d[bus.cdb_isr_arch_id] = bus.cdb_isr_data;
      if (busy_q[bus.cdb_isr_arch_id] && alias_q[bus.cdb_isr_arch_id] == bus.cdb_isr_id)
        busy_d[bus.cdb_isr_arch_id] = 1'b0;
      retire_d = retire_q + 32'd1;
    end
    if (bus.rat_flush)
      busy_d = '0;
    if (bus.rat_register_request && bus.rat_register_arch_id != ARCH_ENTRY_LOG2'(ARCH_ZERO)) begin
      busy_d[bus.rat_register_arch_id]  = 1'b1;
      alias_d[bus.rat_register_arch_id] = bus.rat_register_alias;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      regs_q   <= '0;
      busy_q   <= '0;
      alias_q  <= '0;
      retire_q <= '0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      alias_q  <= alias_d;
      retire_q <= retire_d;
    end
  end

  logic [1:0][ARCH_ENTRY_LOG2-1:0] rs_id;
  logic [1:0]                      rs_ready;
  logic [1:0][DATA_WIDTH-1:0]      rs_data;
  logic [1:0][ROB_ENTRY_LOG2-1:0]  rs_alias;

  assign rs_id[0] = bus.rs1_arch_id;
  assign rs_id[1] = bus.rs2_arch_id;

  for (genvar p = 0; p < 2; p++) begin : g_port
    rat_lookup_port #(
      .ARCH_ENTRY(ARCH_ENTRY), .DATA_WIDTH(DATA_WIDTH),
      .ROB_ENTRY_LOG2(ROB_ENTRY_LOG2), .ARCH_ENTRY_LOG2(ARCH_ENTRY_LOG2)
    ) u_lookup (
      .rs_i(rs_id[p]), .busy_i(busy_q), .alias_i(alias_q), .regs_i(regs_q),
      .commit_fire_i(commit_fire), .commit_arch_i(bus.cdb_isr_arch_id),
      .commit_id_i(bus.cdb_isr_id), .commit_data_i(bus.cdb_isr_data),
      .ready_o(rs_ready[p]), .data_o(rs_data[p]), .alias_o(rs_alias[p])
    );
  end

  assign bus.rs1_ready = rs_ready[0];
  assign bus.rs2_ready = rs_ready[1];
  assign bus.rs1_data  = rs_data[0];
  assign bus.rs2_data  = rs_data[1];
  assign bus.rs1_alias = rs_alias[0];
  assign bus.rs2_alias = rs_alias[1];

  // The ROB must see exactly the commit handshake the table accepted.
  commit_remove_match: assert property (@(posedge CLK) disable iff (RST)
    bus.rat_register_remove == commit_fire);
endmodule

// File: tb/tb_register_alias_table.sv
// Directed scenarios for the register alias table with hand-computed expectations.
module tb_register_alias_table;
  logic CLK = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  register_alias_table_if bus ();
  register_alias_table dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;
  assign bus.rat_register_remove = bus.cdb_isr_request & bus.cdb_isr_grant;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.cdb_isr_request      = 1'b0;
    bus.cdb_isr_arch_id      = '0;
    bus.cdb_isr_id           = '0;
    bus.cdb_isr_data         = '0;
    bus.rat_register_request = 1'b0;
    bus.rat_register_arch_id = '0;
    bus.rat_register_alias   = '0;
    bus.commit_hold          = 1'b0;
    bus.rat_flush            = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    bus.cdb_isr_request = 1'b1;
    bus.rs1_arch_id = 5'd5;
    bus.rs2_arch_id = 5'd0;
    #1;
    checks++; if (bus.cdb_isr_grant !== 1'b0) begin errors++;
      $display("FAIL reset_grant got=%b exp=0", bus.cdb_isr_grant); end
    tick(); tick();
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'h0) begin errors++;
      $display("FAIL reset_x5 got ready=%b data=%h exp ready=1 data=0", bus.rs1_ready, bus.rs1_data); end
    checks++; if (bus.retire_count !== 32'd0) begin errors++;
      $display("FAIL reset_retire got=%0d exp=0", bus.retire_count); end
    idle();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_rename_commit();
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd5; bus.rat_register_alias = 2'd2;
    tick(); idle();
    bus.rs1_arch_id = 5'd5;
    #1;
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs1_alias !== 2'd2) begin errors++;
      $display("FAIL rename_x5 got ready=%b alias=%0d exp ready=0 alias=2", bus.rs1_ready, bus.rs1_alias); end
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd5; bus.cdb_isr_id = 2'd2;
    bus.cdb_isr_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.cdb_isr_grant !== 1'b1 || bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hDEADBEEF)
      begin errors++;
      $display("FAIL bypass_x5 got grant=%b ready=%b data=%h exp 1 1 deadbeef",
               bus.cdb_isr_grant, bus.rs1_ready, bus.rs1_data); end
    tick(); idle();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hDEADBEEF || bus.rs1_alias !== 2'd0)
      begin errors++;
      $display("FAIL commit_x5 got ready=%b data=%h alias=%0d exp 1 deadbeef 0",
               bus.rs1_ready, bus.rs1_data, bus.rs1_alias); end
    checks++; if (bus.retire_count !== 32'd1) begin errors++;
      $display("FAIL retire_1 got=%0d exp=1", bus.retire_count); end
  endtask

  task automatic test_younger_rename();
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd7; bus.rat_register_alias = 2'd1;
    tick();
    bus.rat_register_alias = 2'd3;
    tick(); idle();
    bus.rs2_arch_id = 5'd7;
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd7; bus.cdb_isr_id = 2'd1;
    bus.cdb_isr_data = 32'h11;
    #1;
    checks++; if (bus.rs2_ready !== 1'b0 || bus.rs2_alias !== 2'd3) begin errors++;
      $display("FAIL stale_no_bypass got ready=%b alias=%0d exp 0 3", bus.rs2_ready, bus.rs2_alias); end
    tick(); idle();
    #1;
    checks++; if (bus.rs2_ready !== 1'b0 || bus.rs2_alias !== 2'd3 || bus.retire_count !== 32'd2)
      begin errors++;
      $display("FAIL stale_commit_x7 got ready=%b alias=%0d retire=%0d exp 0 3 2",
               bus.rs2_ready, bus.rs2_alias, bus.retire_count); end
  endtask

  task automatic test_same_cycle();
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd9; bus.cdb_isr_id = 2'd0;
    bus.cdb_isr_data = 32'h99;
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd9; bus.rat_register_alias = 2'd1;
    tick(); idle();
    bus.rs1_arch_id = 5'd9;
    #1;
    checks++; if (bus.rs1_ready !== 1'b0 || bus.rs1_alias !== 2'd1 || bus.retire_count !== 32'd3)
      begin errors++;
      $display("FAIL rename_wins_x9 got ready=%b alias=%0d retire=%0d exp 0 1 3",
               bus.rs1_ready, bus.rs1_alias, bus.retire_count); end
  endtask

  task automatic test_hold();
    bus.commit_hold = 1'b1;
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd11; bus.cdb_isr_id = 2'd0;
    bus.cdb_isr_data = 32'hAB;
    bus.rs1_arch_id = 5'd11;
    #1;
    checks++; if (bus.cdb_isr_grant !== 1'b0) begin errors++;
      $display("FAIL hold_grant got=%b exp=0", bus.cdb_isr_grant); end
    tick();
    checks++; if (bus.rs1_data !== 32'h0 || bus.retire_count !== 32'd3) begin errors++;
      $display("FAIL hold_nowrite got data=%h retire=%0d exp 0 3", bus.rs1_data, bus.retire_count); end
    bus.commit_hold = 1'b0;
    #1;
    checks++; if (bus.cdb_isr_grant !== 1'b1) begin errors++;
      $display("FAIL release_grant got=%b exp=1", bus.cdb_isr_grant); end
    tick(); idle();
    #1;
    checks++; if (bus.rs1_data !== 32'hAB || bus.retire_count !== 32'd4) begin errors++;
      $display("FAIL release_write got data=%h retire=%0d exp ab 4", bus.rs1_data, bus.retire_count); end
  endtask

  task automatic test_x0();
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd0; bus.rat_register_alias = 2'd2;
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd0; bus.cdb_isr_id = 2'd2;
    bus.cdb_isr_data = 32'h55;
    bus.rs1_arch_id = 5'd0;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'h0) begin errors++;
      $display("FAIL x0_same_cycle got ready=%b data=%h exp 1 0", bus.rs1_ready, bus.rs1_data); end
    tick(); idle();
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'h0 || bus.rs1_alias !== 2'd0 ||
                  bus.retire_count !== 32'd5) begin errors++;
      $display("FAIL x0_after got ready=%b data=%h alias=%0d retire=%0d exp 1 0 0 5",
               bus.rs1_ready, bus.rs1_data, bus.rs1_alias, bus.retire_count); end
  endtask

  task automatic test_flush();
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd12; bus.rat_register_alias = 2'd2;
    tick(); idle();
    bus.rs2_arch_id = 5'd12;
    bus.rat_flush = 1'b1;
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd12; bus.cdb_isr_id = 2'd2;
    bus.cdb_isr_data = 32'hFF;
    #1;
    checks++; if (bus.rs2_ready !== 1'b0 || bus.cdb_isr_grant !== 1'b0) begin errors++;
      $display("FAIL flush_pre got ready=%b grant=%b exp 0 0", bus.rs2_ready, bus.cdb_isr_grant); end
    tick(); idle();
    bus.rs1_arch_id = 5'd7;
    bus.rs2_arch_id = 5'd9;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'h11 ||
                  bus.rs2_ready !== 1'b1 || bus.rs2_data !== 32'h99) begin errors++;
      $display("FAIL flush_x7_x9 got %b/%h %b/%h exp 1/11 1/99",
               bus.rs1_ready, bus.rs1_data, bus.rs2_ready, bus.rs2_data); end
    bus.rs1_arch_id = 5'd12;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'h0 || bus.retire_count !== 32'd5)
      begin errors++;
      $display("FAIL flush_x12 got ready=%b data=%h retire=%0d exp 1 0 5",
               bus.rs1_ready, bus.rs1_data, bus.retire_count); end
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd5; bus.rat_register_alias = 2'd1;
    tick();
    bus.rat_flush = 1'b1;
    bus.rat_register_arch_id = 5'd13; bus.rat_register_alias = 2'd3;
    tick(); idle();
    bus.rs1_arch_id = 5'd5;
    bus.rs2_arch_id = 5'd13;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'hDEADBEEF ||
                  bus.rs2_ready !== 1'b0 || bus.rs2_alias !== 2'd3) begin errors++;
      $display("FAIL flush_rename got x5 %b/%h x13 %b/%0d exp 1/deadbeef 0/3",
               bus.rs1_ready, bus.rs1_data, bus.rs2_ready, bus.rs2_alias); end
  endtask

  task automatic test_mid_reset();
    RST = 1'b1;
    bus.cdb_isr_request = 1'b1; bus.cdb_isr_arch_id = 5'd5; bus.cdb_isr_id = 2'd0;
    bus.cdb_isr_data = 32'h77;
    bus.rat_register_request = 1'b1; bus.rat_register_arch_id = 5'd14; bus.rat_register_alias = 2'd2;
    #1;
    checks++; if (bus.cdb_isr_grant !== 1'b0) begin errors++;
      $display("FAIL midreset_grant got=%b exp=0", bus.cdb_isr_grant); end
    tick(); idle();
    RST = 1'b0;
    bus.rs1_arch_id = 5'd14;
    bus.rs2_arch_id = 5'd5;
    #1;
    checks++; if (bus.rs1_ready !== 1'b1 || bus.rs1_data !== 32'h0 || bus.rs2_data !== 32'h0 ||
                  bus.retire_count !== 32'd0) begin errors++;
      $display("FAIL midreset_state got x14 %b/%h x5 %h retire=%0d exp 1/0 0 0",
               bus.rs1_ready, bus.rs1_data, bus.rs2_data, bus.retire_count); end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_hold();
    test_x0();
    test_flush();
    test_mid_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
